// File: rtl/addr_sequencer16.sv
// rtl/addr_sequencer16.sv - 4-bit address sequencer with prescaler, pause, stop and wrap counting
// Walks latched StartAddr..EndAddr up or down, holding each address PRESCALE active cycles.
module addr_sequencer16 #(
  parameter int PRESCALE = 4
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Start,
  input  logic       Stop,
  input  logic       Pause,
  input  logic       Dir,
  input  logic       Wrap,
  input  logic [3:0] StartAddr,
  input  logic [3:0] EndAddr,
  output logic [3:0] Address,
  output logic       AddrValid,
  output logic       Busy,
  output logic       Done,
  output logic [7:0] LoopCount
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [3:0]    addr_nxt;
  logic          valid_nxt;
  logic [7:0]    loop_nxt;
  logic          latch_cfg;
  logic          cfg_dir, cfg_wrap;
  logic [3:0]    cfg_start, cfg_end;

  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    addr_nxt  = Address;
    valid_nxt = 1'b0;
    loop_nxt  = LoopCount;
    latch_cfg = 1'b0;
    case (state)
      S_IDLE: begin
        if (Start && !Stop) begin
          latch_cfg = 1'b1;
          addr_nxt  = StartAddr;
          valid_nxt = 1'b1;
          loop_nxt  = 8'd0;
          presc_nxt = '0;
          state_nxt = S_RUN;
        end
      end
      S_RUN, S_PAUSE: begin
        if (Stop) begin
          state_nxt = S_IDLE;
        end else if (Pause) begin
          state_nxt = S_PAUSE;
        end else begin
          // Leaving PAUSE counts as an active cycle, so each paused cycle adds exactly one hold cycle.
          state_nxt = S_RUN;
          if (presc == PMAX) begin
            presc_nxt = '0;
            if (Address != cfg_end) begin
              addr_nxt  = cfg_dir ? Address - 4'd1 : Address + 4'd1;
              valid_nxt = 1'b1;
            end else if (cfg_wrap) begin
              addr_nxt  = cfg_start;
              valid_nxt = 1'b1;
              loop_nxt  = (LoopCount == 8'hFF) ? LoopCount : LoopCount + 8'd1;
            end else begin
              state_nxt = S_DONE;
            end
          end else begin
            presc_nxt = presc + 1'b1;
          end
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= S_IDLE;
      presc     <= '0;
      Address   <= 4'd0;
      AddrValid <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      LoopCount <= 8'd0;
      cfg_dir   <= 1'b0;
      cfg_wrap  <= 1'b0;
      cfg_start <= 4'd0;
      cfg_end   <= 4'd0;
    end else begin
      state     <= state_nxt;
      presc     <= presc_nxt;
      Address   <= addr_nxt;
      AddrValid <= valid_nxt;
      Busy      <= (state_nxt == S_RUN) || (state_nxt == S_PAUSE);
      Done      <= (state_nxt == S_DONE);
      LoopCount <= loop_nxt;
      if (latch_cfg) begin
        cfg_dir   <= Dir;
        cfg_wrap  <= Wrap;
        cfg_start <= StartAddr;
        cfg_end   <= EndAddr;
      end
    end
  end

endmodule

// File: tb/tb_addr_sequencer16.sv
// tb/tb_addr_sequencer16.sv - randomized and directed bench for addr_sequencer16
// Outputs are compared every cycle against a transaction-level model of the sequence.
module tb_addr_sequencer16;

  localparam int P = 4;
  localparam logic [1:0] M_IDLE = 2'd0, M_BUSY = 2'd1, M_DONE = 2'd2;

  logic       Clk = 1'b0;
  logic       Rst_n, Start, Stop, Pause, Dir, Wrap;
  logic [3:0] StartAddr, EndAddr, Address;
  logic       AddrValid, Busy, Done;
  logic [7:0] LoopCount;
  int         tests = 0;
  int         fails = 0;

  addr_sequencer16 #(.PRESCALE(P)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Stop(Stop), .Pause(Pause),
    .Dir(Dir), .Wrap(Wrap), .StartAddr(StartAddr), .EndAddr(EndAddr),
    .Address(Address), .AddrValid(AddrValid), .Busy(Busy), .Done(Done),
    .LoopCount(LoopCount)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [1:0] mode;
    logic [3:0] addr;
    logic       valid;
    logic [7:0] loop;
    logic [8:0] held;
    logic       dir;
    logic       wrap;
    logic [3:0] sa;
    logic [3:0] ea;
  } model_t;

  model_t m;

  // held = active cycles already spent on the current address
  function automatic model_t model_step(model_t c, logic st, logic sp, logic pa, logic d,
                                        logic w, logic [3:0] sa, logic [3:0] ea);
    model_t n = c;
    n.valid = 1'b0;
    if (c.mode == M_IDLE) begin
      if (st && !sp) begin
        n.mode = M_BUSY; n.dir = d; n.wrap = w; n.sa = sa; n.ea = ea;
        n.addr = sa; n.valid = 1'b1; n.loop = 8'd0; n.held = 9'd0;
      end
    end else if (c.mode == M_BUSY) begin
      if (sp) n.mode = M_IDLE;
      else if (!pa) begin
        if (int'(c.held) == P - 1) begin
          n.held = 9'd0;
          if (c.addr != c.ea) begin
            n.addr  = c.dir ? 4'(c.addr - 4'd1) : 4'(c.addr + 4'd1);
            n.valid = 1'b1;
          end else if (c.wrap) begin
            n.addr  = c.sa;
            n.valid = 1'b1;
            n.loop  = (c.loop == 8'd255) ? 8'd255 : 8'(c.loop + 8'd1);
          end else n.mode = M_DONE;
        end else n.held = 9'(c.held + 9'd1);
      end
    end else n.mode = M_IDLE;
    return n;
  endfunction

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) m <= '0;
    else m <= model_step(m, Start, Stop, Pause, Dir, Wrap, StartAddr, EndAddr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    chk("cyc_address",   32'(Address),   32'(m.addr));
    chk("cyc_addrvalid", 32'(AddrValid), 32'(m.valid));
    chk("cyc_busy",      32'(Busy),      32'(m.mode == M_BUSY));
    chk("cyc_done",      32'(Done),      32'(m.mode == M_DONE));
    chk("cyc_loopcount", 32'(LoopCount), 32'(m.loop));
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Pulses Start for one cycle; returns at the negedge of the first cycle after acceptance.
  task automatic do_start(input logic [3:0] sa, input logic [3:0] ea, input logic d, input logic w);
    @(negedge Clk);
    Start = 1'b1; StartAddr = sa; EndAddr = ea; Dir = d; Wrap = w;
    @(negedge Clk);
    Start = 1'b0; StartAddr = 4'($urandom); EndAddr = 4'($urandom);
    Dir = 1'($urandom); Wrap = 1'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int strobes;
    Rst_n = 1'b0; Start = 1'b0; Stop = 1'b0; Pause = 1'b0;
    Dir = 1'b0; Wrap = 1'b0; StartAddr = 4'd0; EndAddr = 4'd0;
    cycles(2);
    chk("reset_address", 32'(Address), 32'd0);
    chk("reset_busy", 32'(Busy), 32'd0);
    Rst_n = 1'b1;
    cycles(2);

    // 2..5 up, no wrap
    do_start(4'd2, 4'd5, 1'b0, 1'b0);
    chk("up_first_addr", 32'(Address), 32'd2);
    chk("up_first_valid", 32'(AddrValid), 32'd1);
    strobes = 1;
    for (int i = 1; i <= 16; i++) begin
      cycles(1);
      if (AddrValid) strobes++;
      if (i == 4)  chk("up_addr3", 32'(Address), 32'd3);
      if (i == 12) chk("up_addr5", 32'(Address), 32'd5);
      if (i == 15) chk("up_done_not_early", 32'(Done), 32'd0);
    end
    chk("up_done", 32'(Done), 32'd1);
    chk("up_busy_at_done", 32'(Busy), 32'd0);
    chk("up_strobes", 32'(strobes), 32'd4);
    cycles(1);
    chk("up_done_one_cycle", 32'(Done), 32'd0);
    chk("up_addr_kept", 32'(Address), 32'd5);

    // 3 down to D, modulo wrap through 0
    do_start(4'd3, 4'hD, 1'b1, 1'b0);
    cycles(12);
    chk("down_addr0", 32'(Address), 32'd0);
    cycles(4);
    chk("down_addrF", 32'(Address), 32'hF);
    cycles(8);
    chk("down_addrD", 32'(Address), 32'hD);
    cycles(4);
    chk("down_done", 32'(Done), 32'd1);

    // E..1 wrap, then saturate LoopCount
    cycles(2);
    do_start(4'hE, 4'd1, 1'b0, 1'b1);
    cycles(8);
    chk("wrap_addr0", 32'(Address), 32'd0);
    cycles(8);
    chk("wrap_reload", 32'(Address), 32'hE);
    chk("wrap_loop1", 32'(LoopCount), 32'd1);
    cycles(300 * 16);
    chk("wrap_saturate", 32'(LoopCount), 32'd255);
    @(negedge Clk); Stop = 1'b1;
    @(negedge Clk); Stop = 1'b0;
    chk("wrap_stopped", 32'(Busy), 32'd0);

    // pause 10 cycles while prescaler==2, then Stop on a step tick
    do_start(4'd2, 4'd5, 1'b0, 1'b0);
    cycles(2);
    Pause = 1'b1;
    cycles(10);
    Pause = 1'b0;
    cycles(1);
    chk("pause_hold", 32'(Address), 32'd2);
    cycles(1);
    chk("pause_step", 32'(Address), 32'd3);
    cycles(3);
    Stop = 1'b1;
    cycles(1);
    Stop = 1'b0;
    chk("stop_addr", 32'(Address), 32'd3);
    chk("stop_busy", 32'(Busy), 32'd0);
    chk("stop_nodone", 32'(Done), 32'd0);

    // Start+Stop in IDLE, Start during RUN, async reset mid-run
    @(negedge Clk); Start = 1'b1; Stop = 1'b1; StartAddr = 4'd9;
    @(negedge Clk); Start = 1'b0; Stop = 1'b0;
    chk("startstop_idle", 32'(Busy), 32'd0);
    chk("startstop_addr", 32'(Address), 32'd3);
    do_start(4'd9, 4'd12, 1'b0, 1'b1);
    @(negedge Clk); Start = 1'b1; StartAddr = 4'd1;
    @(negedge Clk); Start = 1'b0;
    chk("start_in_run", 32'(Address), 32'd9);
    @(posedge Clk); #2 Rst_n = 1'b0; Start = 1'b1;
    #1;
    chk("async_addr", 32'(Address), 32'd0);
    chk("async_busy", 32'(Busy), 32'd0);
    chk("async_valid", 32'(AddrValid), 32'd0);
    cycles(2);
    chk("no_start_in_reset", 32'(Busy), 32'd0);
    Start = 1'b0; Rst_n = 1'b1;
    cycles(2);

    // random traffic, including occasional resets
    for (int i = 0; i < 4000; i++) begin
      @(negedge Clk);
      Start = ($urandom % 6) == 0;
      Stop = ($urandom % 60) == 0;
      Pause = ($urandom % 5) == 0;
      Dir = 1'($urandom); Wrap = 1'($urandom);
      StartAddr = 4'($urandom); EndAddr = 4'($urandom);
      if (($urandom % 700) == 0) begin
        @(posedge Clk); #2 Rst_n = 1'b0;
        @(negedge Clk); Rst_n = 1'b1;
      end
    end
    Start = 1'b0; Stop = 1'b0; Pause = 1'b0;
    cycles(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/addr_sequencer16.md
ADDR_SEQUENCER16 -- requirements
Module: addr_sequencer16

Interface
REQ-001 SHALL have parameter PRESCALE, default 4, clock cycles each address is held in RUN (legal 1..256).
REQ-002 SHALL have port Clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port Rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port Start  input  1  single-cycle request to begin a sequence.
REQ-005 SHALL have port Stop  input  1  abort request; returns to IDLE without Done.
REQ-006 SHALL have port Pause  input  1  level; freezes sequencing while high.
REQ-007 SHALL have port Dir  input  1  0 = count up, 1 = count down; sampled on accepted Start.
REQ-008 SHALL have port Wrap  input  1  1 = loop from EndAddr back to StartAddr; sampled on accepted Start.
REQ-009 SHALL have port StartAddr  input  4  first address; sampled on accepted Start.
REQ-010 SHALL have port EndAddr  input  4  last address; sampled on accepted Start.
REQ-011 SHALL have port Address  output  4  registered address to the downstream 16x4 lookup table.
REQ-012 SHALL have port AddrValid  output  1  one-cycle strobe, high in the cycle Address takes a new value.
REQ-013 SHALL have port Busy  output  1  high in RUN and PAUSE.
REQ-014 SHALL have port Done  output  1  one-cycle strobe on normal non-wrap completion.
REQ-015 SHALL have port LoopCount  output  8  completed wraps since last accepted Start, saturating at 255.

Function
REQ-016 SHALL implement states IDLE, RUN, PAUSE, DONE; all outputs registered.
REQ-017 IDLE: Start=1 and Stop=0 -> latch Dir/Wrap/StartAddr/EndAddr, Address<=StartAddr, AddrValid=1, LoopCount<=0, prescaler<=0, go RUN; Address/AddrValid visible one cycle after Start.
REQ-018 IDLE: Start and Stop both high -> Stop wins, stay IDLE, no output change.
REQ-019 RUN: prescaler counts 0..PRESCALE-1; step occurs on the edge where prescaler==PRESCALE-1, prescaler then returns to 0; each address held exactly PRESCALE cycles.
REQ-020 Step, Address != latched End: Address +1 (Dir=0) or -1 (Dir=1) modulo 16 (F->0 up, 0->F down), AddrValid=1.
REQ-021 Step, Address == latched End, Wrap=1: Address<=latched Start, AddrValid=1, LoopCount+1 saturating at 255, stay RUN.
REQ-022 Step, Address == latched End, Wrap=0: Address holds, no AddrValid, go DONE.
REQ-023 DONE: Done=1 for exactly one cycle, Busy=0, then IDLE; Address keeps last value.
REQ-024 Start==End: sequence of one address; Wrap=0 -> DONE after PRESCALE cycles; Wrap=1 -> reload same address each PRESCALE cycles with AddrValid and LoopCount increment.
REQ-025 RUN with Pause=1 (and Stop=0) -> PAUSE, no step that edge, prescaler frozen; PAUSE with Pause=0 -> RUN, prescaler resumes from frozen value.
REQ-026 Stop=1 in RUN or PAUSE -> IDLE next edge, overrides a coincident step/Pause, Address holds, no AddrValid, no Done.
REQ-027 Start while Busy or in DONE SHALL be ignored; inputs other than Start/Stop/Pause ignored outside Start acceptance.
REQ-028 AddrValid SHALL never be high for two consecutive cycles when PRESCALE>1.

Reset
REQ-029 Rst_n=0 SHALL immediately (asynchronously) force IDLE, Address=0, AddrValid=0, Busy=0, Done=0, LoopCount=0, prescaler=0, latched config=0.
REQ-030 Reset mid-sequence SHALL discard the sequence; after Rst_n rises, block waits in IDLE for a new Start.
REQ-031 Rst_n release SHALL take effect on the next rising edge of Clk; no Start accepted while Rst_n=0.

Verification
REQ-032 PRESCALE=4, Start with Start=2 End=5 Dir=0 Wrap=0 -> Address 2,3,4,5 each 4 cycles, 4 AddrValid strobes, Done one cycle 4 cycles after Address=5, Busy low after.
REQ-033 Start=E End=1 Dir=0 Wrap=1 -> Address E,F,0,1,E,F...; LoopCount increments at each return to E; run 300 loops -> LoopCount stays 255.
REQ-034 Start=3 End=D Dir=1 Wrap=0 -> Address 3,2,1,0,F,E,D then Done.
REQ-035 Pause high 10 cycles mid-address (prescaler=2) -> Address holds 10 extra cycles, next step 2 cycles after Pause drops; Stop coincident with step tick -> IDLE, Address unchanged, no Done.
REQ-036 Start and Stop same cycle in IDLE -> no change; Start during RUN ignored; Rst_n pulled low mid-RUN -> all outputs 0 without a clock edge.
